// File: rtl/value_stream_fetcher_if.sv
// value_stream_fetcher_if
//   Bundles the fetcher's control, ROM read bus and per-channel stream
//   signals into one port.
//   master : fetcher side (drives rom_en/rom_addr and the stream outputs)
//   slave  : environment side (drives start/base/limit, rom_data, read)
//   Signals:
//     start, base_addr, limit_addr : launch a fetch run (per-channel slices)
//     rom_en, rom_addr, rom_data   : ROM read strobe/address and returned word
//     read, out, empty             : per-channel FWFT FIFO pop / head / flag
//     done, busy                   : per-channel completion, run in progress
interface value_stream_fetcher_if #(
    parameter int CHANNEL_NUM = 4,
    parameter int VAL_BITS    = 8,
    parameter int ADDR_BITS   = 13
);
    logic                             start;
    logic [ADDR_BITS*CHANNEL_NUM-1:0] base_addr;
    logic [ADDR_BITS*CHANNEL_NUM-1:0] limit_addr;
    logic                             rom_en;
    logic [ADDR_BITS-1:0]             rom_addr;
    logic [VAL_BITS-1:0]              rom_data;
    logic [CHANNEL_NUM-1:0]           read;
    logic [VAL_BITS*CHANNEL_NUM-1:0]  out;
    logic [CHANNEL_NUM-1:0]           empty;
    logic [CHANNEL_NUM-1:0]           done;
    logic                             busy;

    modport master (
        input  start, base_addr, limit_addr, rom_data, read,
        output rom_en, rom_addr, out, empty, done, busy
    );

    modport slave (
        output start, base_addr, limit_addr, rom_data, read,
        input  rom_en, rom_addr, out, empty, done, busy
    );
endinterface

// File: rtl/value_stream_fetcher.sv
// value_stream_fetcher
//   Streams per-channel address ranges [base, limit) out of a shared
//   fixed-latency ROM into one FWFT FIFO per channel. One ROM read per cycle
//   is granted round-robin among channels that still have addresses to fetch
//   and guaranteed FIFO room (occupancy + reads in flight < FIFO_DEPTH).
//   A tag pipeline ROM_LATENCY deep tracks which channel each returning
//   word belongs to.
//   Ports:
//     clk  : rising-edge clock
//     rst  : synchronous active-high reset
//     bus  : value_stream_fetcher_if.master (control, ROM bus, streams)
module value_stream_fetcher #(
    parameter int CHANNEL_NUM = 4,
    parameter int VAL_BITS    = 8,
    parameter int ADDR_BITS   = 13,
    parameter int FIFO_DEPTH  = 16,
    parameter int ROM_LATENCY = 1,
    parameter bit WRAP        = 1'b0
) (
    input  logic clk,
    input  logic rst,
    value_stream_fetcher_if.master bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int CH_W  = (CHANNEL_NUM > 1) ? $clog2(CHANNEL_NUM) : 1;

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FLUSH = 2'd2} state_t;
    state_t state, state_nxt;

    logic [CHANNEL_NUM-1:0][ADDR_BITS-1:0] base_q, lim_q, ptr, ptr_inc;
    logic [CHANNEL_NUM-1:0]                active;
    logic [CHANNEL_NUM-1:0][CNT_W-1:0]     inflight;
    logic [CHANNEL_NUM-1:0][CNT_W-1:0]     count;
    logic                                  started;
    logic [CH_W-1:0]                       rr_next;

    // Tag pipeline: stage 0 is loaded at the grant edge, the last stage
    // lines up with the cycle in which rom_data is valid.
    logic [ROM_LATENCY-1:0]                vld_pipe;
    logic [ROM_LATENCY-1:0][CH_W-1:0]      ch_pipe;

    logic [CHANNEL_NUM-1:0] elig, gnt_oh, ret_oh;
    logic                   gnt_any, gnt_vld, ret_vld, load;
    logic [CH_W-1:0]        gnt_ch, ret_ch;

    assign load    = (state == IDLE) && bus.start;
    assign ret_vld = vld_pipe[ROM_LATENCY-1];
    assign ret_ch  = ch_pipe[ROM_LATENCY-1];

    for (genvar i = 0; i < CHANNEL_NUM; i++) begin : g_ch
        // Sum is one bit wider so occupancy + inflight can never alias.
        assign elig[i]    = active[i] &&
                            (({1'b0, count[i]} + {1'b0, inflight[i]}) < (CNT_W+1)'(FIFO_DEPTH));
        assign gnt_oh[i]  = gnt_vld && (gnt_ch == CH_W'(i));
        assign ret_oh[i]  = ret_vld && (ret_ch == CH_W'(i));
        assign ptr_inc[i] = ptr[i] + ADDR_BITS'(1);
    end

    // Round-robin search starting at rr_next; first eligible channel wins.
    always_comb begin
        int idx;
        gnt_any = 1'b0;
        gnt_ch  = '0;
        idx     = 0;
        for (int k = 0; k < CHANNEL_NUM; k++) begin
            idx = int'(rr_next) + k;
            if (idx >= CHANNEL_NUM) idx = idx - CHANNEL_NUM;
            if (!gnt_any && elig[idx]) begin
                gnt_any = 1'b1;
                gnt_ch  = CH_W'(idx);
            end
        end
    end

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // FSM: next state
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start)        state_nxt = RUN;
            RUN:     if (active == '0)     state_nxt = FLUSH;
            FLUSH:   if (vld_pipe == '0)   state_nxt = IDLE;
            default:                       state_nxt = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        bus.busy     = (state == RUN) || (state == FLUSH);
        gnt_vld      = (state == RUN) && gnt_any;
        bus.rom_en   = gnt_vld;
        bus.rom_addr = gnt_vld ? ptr[gnt_ch] : '0;
    end

    // Channel pointers, in-flight counters, arbiter pointer, tag pipeline
    always_ff @(posedge clk) begin
        if (rst) begin
            base_q   <= '0;
            lim_q    <= '0;
            ptr      <= '0;
            active   <= '0;
            inflight <= '0;
            started  <= 1'b0;
            rr_next  <= '0;
            vld_pipe <= '0;
            ch_pipe  <= '0;
        end else begin
            if (load) begin
                base_q  <= bus.base_addr;
                lim_q   <= bus.limit_addr;
                started <= 1'b1;
            end
            for (int i = 0; i < CHANNEL_NUM; i++) begin
                if (load) begin
                    ptr[i]    <= bus.base_addr[i*ADDR_BITS +: ADDR_BITS];
                    active[i] <= bus.base_addr[i*ADDR_BITS +: ADDR_BITS] !=
                                 bus.limit_addr[i*ADDR_BITS +: ADDR_BITS];
                end else if (gnt_oh[i]) begin
                    if (ptr_inc[i] == lim_q[i]) begin
                        if (WRAP) ptr[i] <= base_q[i];
                        else begin
                            ptr[i]    <= ptr_inc[i];
                            active[i] <= 1'b0;
                        end
                    end else begin
                        ptr[i] <= ptr_inc[i];
                    end
                end
                inflight[i] <= inflight[i] + CNT_W'(gnt_oh[i]) - CNT_W'(ret_oh[i]);
            end
            if (gnt_vld)
                rr_next <= (gnt_ch == CH_W'(CHANNEL_NUM-1)) ? '0 : gnt_ch + CH_W'(1);
            vld_pipe[0] <= gnt_vld;
            ch_pipe[0]  <= gnt_ch;
            for (int k = 1; k < ROM_LATENCY; k++) begin
                vld_pipe[k] <= vld_pipe[k-1];
                ch_pipe[k]  <= ch_pipe[k-1];
            end
        end
    end

    // Per-channel FWFT FIFOs; start never touches them, only rst does.
    for (genvar i = 0; i < CHANNEL_NUM; i++) begin : g_fifo
        logic [VAL_BITS-1:0] mem [FIFO_DEPTH];
        logic [PTR_W-1:0]    wr_ptr, rd_ptr;
        logic [CNT_W-1:0]    cnt;
        logic                pop;

        // A pop against an empty FIFO is dropped even if a write lands now.
        assign pop = bus.read[i] && (cnt != '0);

        always_ff @(posedge clk) begin
            if (rst) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                cnt    <= '0;
            end else begin
                if (ret_oh[i]) wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop)       rd_ptr <= rd_ptr + PTR_W'(1);
                cnt <= cnt + CNT_W'(ret_oh[i]) - CNT_W'(pop);
            end
        end

        always_ff @(posedge clk) begin
            if (ret_oh[i]) mem[wr_ptr] <= bus.rom_data;
        end

        assign count[i]                          = cnt;
        assign bus.out[i*VAL_BITS +: VAL_BITS]   = mem[rd_ptr];
        assign bus.empty[i]                      = (cnt == '0);
        assign bus.done[i]                       = started && !active[i] && (inflight[i] == '0);
    end
endmodule
